// File: rtl/rr_arbiter_16bit_4way.sv
// ============================================================================
// rr_arbiter_16bit_4way : 4-way round-robin arbiter with a registered
// valid/ready output slot carrying the granted word and its select code.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_16bit_4way #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [3:0]       req_valid,
  output logic [3:0]       req_ready,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] C_PTR_RST = 2'd3;

  logic [1:0]       ptr_q,      ptr_d;
  logic [1:0]       sel_q,      sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic       w_slot_free;
  logic       w_found;
  logic [1:0] w_grant;
  logic [1:0] w_scan;
  logic       w_xfer;
  logic [WIDTH-1:0] w_word;

  assign w_slot_free = !out_valid_q || out_ready;

  // Priority scan starts just after the last granted channel and ends on it.
  always_comb begin
    w_found = 1'b0;
    w_grant = 2'd0;
    w_scan  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_scan = ptr_q + 2'(k);
      if (!w_found && req_valid[w_scan]) begin
        w_found = 1'b1;
        w_grant = w_scan;
      end
    end
  end

  assign req_ready = (rst_n && w_slot_free && w_found) ? (4'b0001 << w_grant) : 4'b0000;
  assign w_xfer    = |(req_valid & req_ready);

  always_comb begin
    case (w_grant)
      2'd0:    w_word = a;
      2'd1:    w_word = b;
      2'd2:    w_word = c;
      default: w_word = d;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (w_xfer) begin
      ptr_d       = w_grant;
      sel_d       = w_grant;
      out_data_d  = w_word;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= C_PTR_RST;
      sel_q       <= 2'b00;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_16bit_4way.sv
// ============================================================================
// tb_rr_arbiter_16bit_4way : directed vector table, fairness sequence and
// randomized run against a queue-free round-robin reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rr_arbiter_16bit_4way;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b, c, d;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: the word held in the slot and the last grant.
  logic        m_valid;
  logic [15:0] m_data;
  logic [1:0]  m_sel;
  int          m_ptr;

  typedef struct {
    logic        rst_n;
    logic [3:0]  rv;
    logic        ordy;
    logic [15:0] c;
    logic [3:0]  e_ready;
    logic        e_valid;
    logic [1:0]  e_sel;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl[23];

  rr_arbiter_16bit_4way #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [3:0] rv, logic ordy, logic [15:0] cc,
                              logic [3:0] er, logic ev, logic [1:0] es, logic [15:0] ed);
    vec_t v;
    v.rst_n = r;  v.rv = rv;  v.ordy = ordy;  v.c = cc;
    v.e_ready = er;  v.e_valid = ev;  v.e_sel = es;  v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First requesting channel after the last grant, wrapping mod 4.
  function automatic logic [3:0] model_ready();
    int ch;
    if (!rst_n || (m_valid && !out_ready)) return 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      ch = (m_ptr + k) % 4;
      if (req_valid[ch]) return 4'(1 << ch);
    end
    return 4'b0000;
  endfunction

  function automatic logic [15:0] chan_word(int ch);
    case (ch)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  task automatic drive(input logic r, input logic [3:0] rv, input logic ordy,
                       input logic [15:0] da, input logic [15:0] db,
                       input logic [15:0] dc, input logic [15:0] dd);
    rst_n = r;  req_valid = rv;  out_ready = ordy;
    a = da;  b = db;  c = dc;  d = dd;
    @(negedge clk);
  endtask

  // Apply the model's view of the coming edge, then move past it.
  task automatic advance();
    logic [3:0] g;
    g = model_ready();
    if (!rst_n) begin
      m_valid = 1'b0;  m_data = 16'h0;  m_sel = 2'b00;  m_ptr = 3;
    end else if (g != 4'b0000) begin
      for (int ch = 0; ch < 4; ch++) begin
        if (g[ch]) begin
          m_data = chan_word(ch);  m_sel = 2'(ch);  m_ptr = ch;  m_valid = 1'b1;
        end
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".ready"}, 32'(req_ready), 32'(model_ready()));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".sel"},  32'(sel),      32'(m_sel));
      chk({tag, ".data"}, 32'(out_data), 32'(m_data));
    end
  endtask

  initial begin
    int gcount[4];
    int total;
    m_valid = 1'b0;  m_data = 16'h0;  m_sel = 2'b00;  m_ptr = 3;

    tbl[0]  = mk(0, 4'hF, 1, 16'h3333, 4'h0, 0, 2'd0, 16'h0000);
    tbl[1]  = mk(0, 4'hF, 1, 16'h3333, 4'h0, 0, 2'd0, 16'h0000);
    tbl[2]  = mk(1, 4'h4, 1, 16'hC0DE, 4'h4, 0, 2'd0, 16'h0000);
    tbl[3]  = mk(1, 4'h0, 1, 16'h3333, 4'h0, 1, 2'd2, 16'hC0DE);
    tbl[4]  = mk(1, 4'h0, 1, 16'h3333, 4'h0, 0, 2'd2, 16'hC0DE);
    tbl[5]  = mk(0, 4'hF, 1, 16'h3333, 4'h0, 0, 2'd2, 16'hC0DE);
    tbl[6]  = mk(1, 4'hF, 1, 16'h3333, 4'h1, 0, 2'd0, 16'h0000);
    tbl[7]  = mk(1, 4'hF, 1, 16'h3333, 4'h2, 1, 2'd0, 16'h1111);
    tbl[8]  = mk(1, 4'hF, 1, 16'h3333, 4'h4, 1, 2'd1, 16'h2222);
    tbl[9]  = mk(1, 4'hF, 1, 16'h3333, 4'h8, 1, 2'd2, 16'h3333);
    tbl[10] = mk(1, 4'hF, 1, 16'h3333, 4'h1, 1, 2'd3, 16'h4444);
    tbl[11] = mk(1, 4'hF, 0, 16'h3333, 4'h0, 1, 2'd0, 16'h1111);
    tbl[12] = mk(1, 4'hF, 0, 16'h3333, 4'h0, 1, 2'd0, 16'h1111);
    tbl[13] = mk(1, 4'hF, 0, 16'h3333, 4'h0, 1, 2'd0, 16'h1111);
    tbl[14] = mk(1, 4'hF, 1, 16'h3333, 4'h2, 1, 2'd0, 16'h1111);
    tbl[15] = mk(1, 4'h4, 1, 16'h3333, 4'h4, 1, 2'd1, 16'h2222);
    tbl[16] = mk(1, 4'h9, 1, 16'h3333, 4'h8, 1, 2'd2, 16'h3333);
    tbl[17] = mk(1, 4'h9, 1, 16'h3333, 4'h1, 1, 2'd3, 16'h4444);
    tbl[18] = mk(1, 4'h9, 1, 16'h3333, 4'h8, 1, 2'd0, 16'h1111);
    tbl[19] = mk(1, 4'h0, 0, 16'h3333, 4'h0, 1, 2'd3, 16'h4444);
    tbl[20] = mk(0, 4'h0, 0, 16'h3333, 4'h0, 1, 2'd3, 16'h4444);
    tbl[21] = mk(1, 4'hF, 0, 16'h3333, 4'h1, 0, 2'd0, 16'h0000);
    tbl[22] = mk(1, 4'h0, 1, 16'h3333, 4'h0, 1, 2'd0, 16'h1111);

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rst_n, tbl[i].rv, tbl[i].ordy, 16'h1111, 16'h2222, tbl[i].c, 16'h4444);
      chk($sformatf("vec%0d.ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d.sel",   i), 32'(sel),       32'(tbl[i].e_sel));
      chk($sformatf("vec%0d.data",  i), 32'(out_data),  32'(tbl[i].e_data));
      advance();
    end

    // Fairness: all four held valid for eight transfers, each wins twice.
    drive(1'b0, 4'hF, 1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    advance();
    for (int ch = 0; ch < 4; ch++) gcount[ch] = 0;
    total = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'hF, 1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
      for (int ch = 0; ch < 4; ch++) begin
        if (req_ready[ch]) begin
          gcount[ch]++;
          total++;
        end
      end
      advance();
    end
    chk("fair.total", 32'(total), 32'd8);
    for (int ch = 0; ch < 4; ch++) chk($sformatf("fair.ch%0d", ch), 32'(gcount[ch]), 32'd2);

    // Randomized traffic, including occasional reset and backpressure.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) != 0), 4'($urandom), ($urandom_range(0, 3) != 0),
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      chk_model($sformatf("rnd%0d", i));
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
